// File: rtl/add_share_pkg.sv
// Shared types, constants and the round-robin pick helper for add_share_arb.
package add_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DONE_CNT_W = 16;

  // Widest requester set the pick helper handles.
  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                    input logic [MAX_ID_W-1:0] ptr,
                                    input int unsigned         n);
    pick_t       p;
    int unsigned cand;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = (32'(ptr) + k) % n;
      if (k < n && !p.found && valid[cand[MAX_ID_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = cand[MAX_ID_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/add_define.sv
// Shared combinational increment datapath: b = a + INCREMENT.
`ifndef INCREMENT
`define INCREMENT 1
`endif

module add_define #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  output logic [DW-1:0] b
);

  // Carry out of the top bit is discarded, so the result wraps.
  assign b = a + DW'(`INCREMENT);

endmodule

// File: rtl/add_share_arb_rr_arb_core.sv
// Combinational round-robin pick: one-hot grant and index from req_valid, rr_ptr.
module rr_arb_core
  import add_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               found
);

  pick_t w_pick;

  // Search starts at rr_ptr so the last winner has lowest priority next time.
  always_comb begin
    w_pick    = rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(rr_ptr), NUM_REQ);
    found     = w_pick.found;
    grant_idx = ID_W'(w_pick.idx);
    grant     = w_pick.found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin sharing of one add_define incrementer between NUM_REQ requesters.
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [DONE_CNT_W-1:0] done_count
);

  state_t                r_state;
  state_t                w_next;
  logic [DW-1:0]         r_op;
  logic [DW-1:0]         r_res;
  logic [ID_W-1:0]       r_id;
  logic [ID_W-1:0]       r_rr_ptr;
  logic                  r_rsp_valid;
  logic [DONE_CNT_W-1:0] r_done;

  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_grant_idx;
  logic                  w_found;
  logic                  w_grant_en;
  logic                  w_accept;
  logic                  w_rsp_fire;
  logic [DW-1:0]         w_sum;

  rr_arb_core #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .found     (w_found)
  );

  add_define #(
    .DW (DW)
  ) u_add (
    .a (r_op),
    .b (w_sum)
  );

  // Grants are possible when idle, or when the pending response drains this cycle.
  always_comb begin
    w_rsp_fire = (r_state == RESP) && rsp_ready;
    w_grant_en = (r_state == IDLE) || w_rsp_fire;
    w_accept   = w_grant_en && w_found;
    req_ready  = w_accept ? w_grant : '0;
  end

  // Next-state logic for IDLE -> EXEC -> RESP.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = w_found ? EXEC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, operand/result capture, round-robin pointer and completion counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values, order-independent.
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_res       <= '0;
      r_id        <= '0;
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_done      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= req_data[w_grant_idx*DW +: DW];
        r_id     <= w_grant_idx;
        r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
      end
      if (r_state == EXEC) begin
        r_res       <= w_sum;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
        r_done      <= r_done + 1'b1;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_res;
  assign rsp_id     = r_id;
  assign busy       = (r_state != IDLE);
  assign done_count = r_done;

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: vector table plus scoreboard and corner sequences.
module tb_add_share_arb;

  localparam int NUM_REQ = 4;
  localparam int DW      = 16;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;
  logic [15:0]           done_count;

  add_share_arb #(
    .NUM_REQ (NUM_REQ),
    .DW      (DW),
    .ID_W    (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   data;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic [NUM_REQ-1:0]          valid;
    logic [NUM_REQ-1:0][DW-1:0]  op;
    int                          n;
    logic [NUM_REQ-1:0][ID_W-1:0] eid;
    logic [NUM_REQ-1:0][DW-1:0]  edata;
    logic [15:0]                 edone;
  } vec_t;

  vec_t vecs[5];

  // Snapshots taken at the falling edge by tick().
  logic [NUM_REQ-1:0] s_ready;
  logic               s_rvalid;
  logic [DW-1:0]      s_rdata;
  logic [ID_W-1:0]    s_rid;
  logic               s_busy;
  logic [15:0]        s_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample at the falling edge, then let the rising edge happen; granted requesters drop valid.
  task automatic tick();
    @(negedge clk);
    s_ready  = req_ready;
    s_rvalid = rsp_valid;
    s_rdata  = rsp_data;
    s_rid    = rsp_id;
    s_busy   = busy;
    s_done   = done_count;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~s_ready;
  endtask

  // Scoreboard and handshake-rule monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if ((req_ready & ~req_valid) != '0)
        check("ready_without_valid", 32'(req_ready), 32'(req_ready & req_valid));
      if ($countones(req_ready) > 1)
        check("ready_onehot", 32'($countones(req_ready)), 32'd1);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", {15'd0, rsp_id, rsp_data[14:0]}, 32'hDEAD);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    tick();
    check("reset_rsp_valid", 32'(s_rvalid), 32'd0);
    check("reset_busy", 32'(s_busy), 32'd0);
    check("reset_done_count", 32'(s_done), 32'd0);
    check("reset_req_ready", 32'(s_ready), 32'd0);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check({name, "_drain_timeout"}, 32'(q.size()), 32'd0);
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    int   got;
    int   budget;
    int   grant_cyc;
    int   rsp_cyc[NUM_REQ];
    v = vecs[idx];
    do_reset();
    for (int k = 0; k < v.n; k++) q.push_back('{id: v.eid[k], data: v.edata[k]});
    req_data  = v.op;
    req_valid = v.valid;
    rsp_ready = 1'b1;
    got       = 0;
    budget    = 40;
    grant_cyc = -1;
    while (got < v.n && budget > 0) begin
      tick();
      if (s_ready != '0 && grant_cyc < 0) grant_cyc = cyc;
      if (s_rvalid) begin
        rsp_cyc[got] = cyc;
        got++;
      end
      budget--;
    end
    check($sformatf("vec%0d_rsp_count", idx), 32'(got), 32'(v.n));
    if (got == v.n) begin
      check($sformatf("vec%0d_latency", idx), 32'(rsp_cyc[0] - grant_cyc), 32'd2);
      for (int k = 1; k < v.n; k++)
        check($sformatf("vec%0d_spacing%0d", idx, k), 32'(rsp_cyc[k] - rsp_cyc[k-1]), 32'd2);
    end
    tick();
    check($sformatf("vec%0d_done_count", idx), 32'(s_done), 32'(v.edone));
    check($sformatf("vec%0d_queue_empty", idx), 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int grants;
    int gidx;
    logic got3;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;

    // Single request from requester 0.
    vecs[0] = '{valid: 4'b0001, op: '0, n: 1, eid: '0, edata: '0, edone: 16'd1};
    vecs[0].op[0] = 16'd14;  vecs[0].eid[0] = 2'd0;  vecs[0].edata[0] = 16'd15;
    // All four requesters, served 0..3 every two cycles.
    vecs[1] = '{valid: 4'b1111, op: '0, n: 4, eid: '0, edata: '0, edone: 16'd4};
    vecs[1].op[0] = 16'd10;  vecs[1].op[1] = 16'd20;  vecs[1].op[2] = 16'd30;  vecs[1].op[3] = 16'd40;
    vecs[1].eid[0] = 2'd0;   vecs[1].eid[1] = 2'd1;   vecs[1].eid[2] = 2'd2;   vecs[1].eid[3] = 2'd3;
    vecs[1].edata[0] = 16'd11; vecs[1].edata[1] = 16'd21; vecs[1].edata[2] = 16'd31; vecs[1].edata[3] = 16'd41;
    // Wrap: 16'hFFFF + 1 = 0.
    vecs[2] = '{valid: 4'b0100, op: '0, n: 1, eid: '0, edata: '0, edone: 16'd1};
    vecs[2].op[2] = 16'hFFFF; vecs[2].eid[0] = 2'd2; vecs[2].edata[0] = 16'h0000;
    // Sparse mask, unused lanes carry junk.
    vecs[3] = '{valid: 4'b1010, op: '0, n: 2, eid: '0, edata: '0, edone: 16'd2};
    vecs[3].op[0] = 16'hAAAA; vecs[3].op[1] = 16'd5; vecs[3].op[2] = 16'h5555; vecs[3].op[3] = 16'd100;
    vecs[3].eid[0] = 2'd1;   vecs[3].eid[1] = 2'd3;
    vecs[3].edata[0] = 16'd6; vecs[3].edata[1] = 16'd101;
    // Upper pair.
    vecs[4] = '{valid: 4'b1100, op: '0, n: 2, eid: '0, edata: '0, edone: 16'd2};
    vecs[4].op[2] = 16'h7FFF; vecs[4].op[3] = 16'h1234;
    vecs[4].eid[0] = 2'd2;   vecs[4].eid[1] = 2'd3;
    vecs[4].edata[0] = 16'h8000; vecs[4].edata[1] = 16'h1235;

    for (int i = 0; i < 5; i++) apply_vec(i);

    // Backpressure: response held while rsp_ready is low, grant lands in release cycle.
    do_reset();
    q.push_back('{id: 2'd0, data: 16'd21});
    q.push_back('{id: 2'd1, data: 16'd31});
    req_data  = {16'd0, 16'd0, 16'd30, 16'd20};
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    tick();
    check("bp_first_grant", 32'(s_ready), 32'b0001);
    for (int b = 0; b < 10 && !s_rvalid; b++) tick();
    check("bp_rsp_valid_seen", 32'(s_rvalid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", 32'(s_rvalid), 32'd1);
      check("bp_hold_data", 32'(s_rdata), 32'd21);
      check("bp_hold_id", 32'(s_rid), 32'd0);
      check("bp_no_grant", 32'(s_ready), 32'd0);
      check("bp_busy", 32'(s_busy), 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_grant", 32'(s_ready), 32'b0010);
    drain("bp");
    tick();
    check("bp_done_count", 32'(s_done), 32'd2);

    // Reset during EXEC discards the transaction (done_count is 2 going in).
    req_data  = {16'd0, 16'd0, 16'd0, 16'd7};
    req_valid = 4'b0001;
    tick();
    check("rst_mid_grant", 32'(s_ready), 32'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_rsp_valid", 32'(s_rvalid), 32'd0);
    check("rst_mid_busy", 32'(s_busy), 32'd0);
    check("rst_mid_done_count", 32'(s_done), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rst_mid_no_rsp", 32'(s_rvalid), 32'd0);
    end

    // Fairness: requester 1 always valid, requester 3 valid once.
    do_reset();
    req_data  = {16'd200, 16'd0, 16'd100, 16'd0};
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    grants    = 0;
    got3      = 1'b0;
    for (int b = 0; b < 30 && !got3; b++) begin
      tick();
      if (s_ready != '0) begin
        grants++;
        gidx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (s_ready[i]) gidx = i;
        q.push_back('{id: ID_W'(gidx), data: req_data[gidx*DW +: DW] + 16'd1});
        if (gidx == 3) got3 = 1'b1;
      end
      if (!got3) req_valid[1] = 1'b1;
    end
    check("fair_r3_granted", 32'(got3), 32'd1);
    check("fair_within_4", 32'(grants <= NUM_REQ), 32'd1);
    req_valid = '0;
    drain("fair");
    tick();
    check("fair_done_count", 32'(s_done), 32'(grants));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_share_arb.md
Name: add_share_arb

Overview:
Shares the single combinational add_define increment datapath (b = a + `INCREMENT) between NUM_REQ requesters.
- Round-robin arbitration; operand captured into an input register; result captured into a response register tagged with the requester ID.
- Only one transaction is in flight at a time.
- Sits between the requesting blocks and the add_define instance and owns all sequencing of it.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DW, 16, operand/result width; matches add_define port width
ID_W, $clog2(NUM_REQ), requester-ID width

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_data  in  NUM_REQ*DW  packed operands, requester i at [i*DW +: DW]
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  DW  incremented operand
rsp_id  out  ID_W  index of requester that issued the operand
busy  out  1  high while a transaction is in flight
done_count  out  16  count of completed responses, wraps

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst). On rst, at the next clk edge:
  - state=IDLE, all outputs 0, rr_ptr=0, operand/result registers 0.
  - Reset mid-transaction discards that transaction; no response is produced.
- State machine: IDLE -> EXEC -> RESP.
  - IDLE:
    - If any req_valid is set, grant the requester selected by round-robin from rr_ptr; req_ready[g]=1 combinationally in the same cycle.
    - Capture req_data[g] into op_q and g into id_q.
    - rr_ptr <= (g+1) mod NUM_REQ; go to EXEC.
  - EXEC:
    - op_q drives add_define.a.
    - Register res_q <= b; rsp_valid <= 1; go to RESP.
  - RESP:
    - rsp_data=res_q and rsp_id=id_q are held stable while rsp_valid && !rsp_ready.
    - On rsp_ready: done_count++ and rsp_valid drops.
      - If any req_valid is set in that same cycle, grant immediately (as in IDLE) and go to EXEC.
      - Otherwise go to IDLE.
- Latency:
  - Accept at cycle N gives rsp_valid at N+2.
  - Sustained throughput is one result per 2 cycles when rsp_ready is held high.
- Handshakes:
  - req_ready is asserted only in IDLE, or in RESP with rsp_ready.
  - req_ready is never asserted for a requester whose req_valid is low.
  - At most one req_ready bit is high per cycle.
  - Requesters may drop req_valid before grant without error.
- Arithmetic:
  - rsp_data = (operand + `INCREMENT) mod 2^DW; 16'hFFFF + 1 = 16'h0000, with no carry out.
  - done_count wraps 16'hFFFF -> 0.
- Fairness:
  - A requester holding req_valid is granted within NUM_REQ grants.
  - rr_ptr advances only on a grant.
- busy = (state != IDLE).
- Unused req_data lanes are ignored.

Decomposition:
- Package add_share_pkg:
  - state enum typedef {IDLE, EXEC, RESP}.
  - localparam DONE_CNT_W=16.
  - Function rr_pick(valid, ptr) returning the grant index and a found flag.
- One sub-module is natural: rr_arb_core (combinational round-robin pick from req_valid and rr_ptr, outputs a one-hot grant and its index).
- add_define is instantiated unchanged as the shared datapath.

Test Plan (default build, `INCREMENT=1):
1. Reset, then requester 0 sends 14, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=15, rsp_id=0, done_count=1.
2. All four requesters valid with operands 10,20,30,40, rsp_ready=1 -> responses in order id 0,1,2,3, data 11,21,31,41, one response every 2 cycles, done_count=4.
3. Requester 2 sends 16'hFFFF -> rsp_data=16'h0000, rsp_id=2.
4. rsp_ready held low 5 cycles after rsp_valid -> rsp_data and rsp_id stable for those cycles, req_ready stays 0, no new grant; release -> next grant occurs in the release cycle.
5. rst asserted during EXEC of operand 7 -> next cycle: rsp_valid=0, busy=0, done_count=0; no response for 7 appears afterwards.
6. Requester 1 continuously valid, requester 3 valid once -> requester 3 granted within 4 grants; no req_ready asserted when req_valid is 0.
